// File: rtl/reg_bus_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_pkg
// Shared definitions for the register-bus master bridge:
//   - bridge_state_e : FSM state encoding (IDLE, WRITE, READ, RESP)
//   - READ_LATENCY_MIN / READ_LATENCY_MAX : legal range of the read strobe length
//   - LAT_CNT_W : width of the read-latency down-counter
//   - read_latency_ok() : range check used at elaboration time
// ---------------------------------------------------------------------------
package reg_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } bridge_state_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 15;

   // Wide enough to hold READ_LATENCY_MAX - 1.
   localparam int LAT_CNT_W = 4;

   function automatic bit read_latency_ok(input int lat);
      return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/reg_bus_master_bridge_if.sv
// ---------------------------------------------------------------------------
// reg_bus_master_bridge_if
// Groups the request/response handshake and the register-bus signals.
//   request  : req_valid, req_ready, req_write, req_addr, req_wdata
//   response : rsp_valid, rsp_ready, rsp_write, rsp_rdata
//   reg bus  : address, write_enable, write_data, read_enable, read_data
// Modports:
//   master : the bridge view (accepts requests, drives the register bus)
//   slave  : the environment view (issues requests, serves the register bus)
// ---------------------------------------------------------------------------
interface reg_bus_master_bridge_if #(
   parameter int ADDR_W  = 33,
   parameter int WDATA_W = 33,
   parameter int RDATA_W = 21
);
   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [ADDR_W-1:0]  req_addr;
   logic [WDATA_W-1:0] req_wdata;

   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_write;
   logic [RDATA_W-1:0] rsp_rdata;

   logic [ADDR_W-1:0]  address;
   logic               write_enable;
   logic [WDATA_W-1:0] write_data;
   logic               read_enable;
   logic [RDATA_W-1:0] read_data;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, read_data,
      output req_ready, rsp_valid, rsp_write, rsp_rdata,
             address, write_enable, write_data, read_enable
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, read_data,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata,
             address, write_enable, write_data, read_enable
   );

endinterface

// File: rtl/reg_bus_master_bridge_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current (registered) count, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Count up on inc unless already saturated.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/reg_bus_master_bridge.sv
// ---------------------------------------------------------------------------
// reg_bus_master_bridge
// Turns one valid/ready request at a time into a register-bus write strobe
// (1 cycle) or read strobe (READ_LATENCY cycles), then returns a valid/ready
// response. All outputs come from registers.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset; aborts any transaction
//   bus      : request, response and register-bus signals (master modport)
//   busy     : FSM is not IDLE
//   wr_count : completed writes, saturating
//   rd_count : completed reads, saturating
// ---------------------------------------------------------------------------
module reg_bus_master_bridge
   import reg_bus_pkg::*;
#(
   parameter int ADDR_W       = 33,
   parameter int WDATA_W      = 33,
   parameter int RDATA_W      = 21,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   reg_bus_master_bridge_if.master bus,
   output logic                   busy,
   output logic [CNT_W-1:0]       wr_count,
   output logic [CNT_W-1:0]       rd_count
);

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
      $error("reg_bus_master_bridge: READ_LATENCY=%0d outside %0d..%0d",
             READ_LATENCY, READ_LATENCY_MIN, READ_LATENCY_MAX);
   end

   // Down-counter load value: the last READ cycle is the one where it reads 0.
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

   bridge_state_e        state_r;
   logic [LAT_CNT_W-1:0] lat_cnt_r;
   logic                 req_ready_r;
   logic [ADDR_W-1:0]    address_r;
   logic [WDATA_W-1:0]   write_data_r;
   logic                 write_enable_r;
   logic                 read_enable_r;
   logic                 rsp_valid_r;
   logic                 rsp_write_r;
   logic [RDATA_W-1:0]   rsp_rdata_r;
   logic                 busy_r;

   logic                 wr_done_s;
   logic                 rd_done_s;

   // Bridge FSM with all outputs registered alongside the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         lat_cnt_r      <= '0;
         req_ready_r    <= 1'b0;
         address_r      <= '0;
         write_data_r   <= '0;
         write_enable_r <= 1'b0;
         read_enable_r  <= 1'b0;
         rsp_valid_r    <= 1'b0;
         rsp_write_r    <= 1'b0;
         rsp_rdata_r    <= '0;
         busy_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // req_ready_r is low only in the first cycle out of reset.
               req_ready_r <= 1'b1;
               if (bus.req_valid && req_ready_r) begin
                  req_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  address_r   <= bus.req_addr;
                  if (bus.req_write) begin
                     state_r        <= ST_WRITE;
                     write_enable_r <= 1'b1;
                     write_data_r   <= bus.req_wdata;
                  end else begin
                     state_r       <= ST_READ;
                     read_enable_r <= 1'b1;
                     lat_cnt_r     <= LAT_LOAD;
                  end
               end
            end
            ST_WRITE: begin
               state_r        <= ST_RESP;
               write_enable_r <= 1'b0;
               rsp_valid_r    <= 1'b1;
               rsp_write_r    <= 1'b1;
               rsp_rdata_r    <= '0;
            end
            ST_READ: begin
               if (lat_cnt_r == '0) begin
                  // Last read cycle: the slave's combinational data is valid now.
                  state_r       <= ST_RESP;
                  read_enable_r <= 1'b0;
                  rsp_valid_r   <= 1'b1;
                  rsp_write_r   <= 1'b0;
                  rsp_rdata_r   <= bus.read_data;
               end else begin
                  lat_cnt_r <= lat_cnt_r - LAT_CNT_W'(1);
               end
            end
            ST_RESP: begin
               // req_ready_r stays low here, so no request is taken on the
               // handshake cycle; it rises as the FSM returns to IDLE.
               if (bus.rsp_ready) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_r <= 1'b0;
                  rsp_write_r <= 1'b0;
                  rsp_rdata_r <= '0;
                  busy_r      <= 1'b0;
                  req_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               write_enable_r <= 1'b0;
               read_enable_r  <= 1'b0;
               rsp_valid_r    <= 1'b0;
               rsp_write_r    <= 1'b0;
               rsp_rdata_r    <= '0;
               busy_r         <= 1'b0;
               req_ready_r    <= 1'b0;
            end
         endcase
      end
   end

   assign wr_done_s = rsp_valid_r & bus.rsp_ready & rsp_write_r;
   assign rd_done_s = rsp_valid_r & bus.rsp_ready & ~rsp_write_r;

   sat_counter #(.W(CNT_W)) u_wr_counter (
      .clock (clock),
      .reset (reset),
      .inc   (wr_done_s),
      .count (wr_count)
   );

   sat_counter #(.W(CNT_W)) u_rd_counter (
      .clock (clock),
      .reset (reset),
      .inc   (rd_done_s),
      .count (rd_count)
   );

   assign bus.req_ready    = req_ready_r;
   assign bus.address      = address_r;
   assign bus.write_enable = write_enable_r;
   assign bus.write_data   = write_data_r;
   assign bus.read_enable  = read_enable_r;
   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_write    = rsp_write_r;
   assign bus.rsp_rdata    = rsp_rdata_r;
   assign busy             = busy_r;

endmodule

// File: tb/tb_reg_bus_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master_bridge
// Self-checking bench. dut_a: READ_LATENCY=3, CNT_W=16 (directed and random
// traffic with a response scoreboard). dut_b: READ_LATENCY=1, CNT_W=4
// (counter saturation and single-cycle read).
// ---------------------------------------------------------------------------
module tb_reg_bus_master_bridge;
   import reg_bus_pkg::*;

   localparam int ADDR_W     = 33;
   localparam int WDATA_W    = 33;
   localparam int RDATA_W    = 21;
   localparam int RL_A       = 3;
   localparam int CNT_W_A    = 16;
   localparam int RL_B       = 1;
   localparam int CNT_W_B    = 4;
   localparam int WAIT_LIMIT = 200;
   localparam int N_RANDOM   = 1000;

   typedef struct packed {
      logic               write;
      logic [RDATA_W-1:0] rdata;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_wr     = 0;
   int   m_rd     = 0;
   int   we_len   = 0;
   int   re_len   = 0;
   int   re_run   = 0;
   int   rsp_mode = 0;
   int   n_wr_issued = 0;
   int   n_rd_issued = 0;
   rsp_t exp_q[$];

   // Slave register contents as a function of address.
   function automatic logic [RDATA_W-1:0] slave_fn(input logic [ADDR_W-1:0] a);
      return a[RDATA_W-1:0] ^ 21'h0129E;
   endfunction

   function automatic int sat_a(input int n);
      return (n > 65535) ? 65535 : n;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- DUT A ----------------
   reg_bus_master_bridge_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus_a ();
   logic               busy_a;
   logic [CNT_W_A-1:0] wr_count_a;
   logic [CNT_W_A-1:0] rd_count_a;

   reg_bus_master_bridge #(
      .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W),
      .READ_LATENCY(RL_A), .CNT_W(CNT_W_A)
   ) dut_a (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus_a),
      .busy     (busy_a),
      .wr_count (wr_count_a),
      .rd_count (rd_count_a)
   );

   // Slave returns valid data only in the last read-strobe cycle.
   always @(posedge clock) re_run <= bus_a.read_enable ? re_run + 1 : 0;
   assign bus_a.read_data = (bus_a.read_enable && (re_run == RL_A - 1)) ?
                            slave_fn(bus_a.address) : {RDATA_W{1'b1}};

   // ---------------- DUT B ----------------
   reg_bus_master_bridge_if #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W)) bus_b ();
   logic               busy_b;
   logic [CNT_W_B-1:0] wr_count_b;
   logic [CNT_W_B-1:0] rd_count_b;

   reg_bus_master_bridge #(
      .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W),
      .READ_LATENCY(RL_B), .CNT_W(CNT_W_B)
   ) dut_b (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus_b),
      .busy     (busy_b),
      .wr_count (wr_count_b),
      .rd_count (rd_count_b)
   );

   assign bus_b.read_data = bus_b.read_enable ? slave_fn(bus_b.address) : {RDATA_W{1'b0}};

   // Random response backpressure for the mixed-traffic phase.
   always @(posedge clock) begin
      #1;
      if (rsp_mode == 1) bus_a.rsp_ready = 1'($urandom_range(0, 1));
   end

   // Scoreboard / protocol monitor for dut_a, sampled mid-cycle.
   always @(negedge clock) begin
      rsp_t e;
      if (!reset) begin
         exp_q.delete();
         m_wr   = 0;
         m_rd   = 0;
         we_len = 0;
         re_len = 0;
      end else begin
         if (bus_a.write_enable || bus_a.read_enable)
            check_eq("strobe_overlap", bus_a.write_enable & bus_a.read_enable, 1'b0);
         if (bus_a.write_enable) we_len++;
         else if (we_len != 0) begin
            check_eq("we_len", we_len, 1);
            we_len = 0;
         end
         if (bus_a.read_enable) re_len++;
         else if (re_len != 0) begin
            check_eq("re_len", re_len, RL_A);
            re_len = 0;
         end
         if (bus_a.req_valid && bus_a.req_ready) begin
            e.write = bus_a.req_write;
            e.rdata = bus_a.req_write ? {RDATA_W{1'b0}} : slave_fn(bus_a.req_addr);
            exp_q.push_back(e);
         end
         if (bus_a.rsp_valid && bus_a.rsp_ready) begin
            check_eq("rsp_expected", exp_q.size() > 0, 1'b1);
            check_eq("wr_count_run", wr_count_a, sat_a(m_wr));
            check_eq("rd_count_run", rd_count_a, sat_a(m_rd));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("rsp_write", bus_a.rsp_write, e.write);
               check_eq("rsp_rdata", bus_a.rsp_rdata, e.rdata);
               if (e.write) m_wr++;
               else m_rd++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [WDATA_W-1:0] d);
      int t;
      t = 0;
      while (!bus_a.req_ready && t < WAIT_LIMIT) begin
         tick();
         t++;
      end
      if (t >= WAIT_LIMIT) check_eq("req_ready_timeout", bus_a.req_ready, 1'b1);
      bus_a.req_valid = 1'b1;
      bus_a.req_write = wr;
      bus_a.req_addr  = a;
      bus_a.req_wdata = d;
      tick();
      bus_a.req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((busy_a || exp_q.size() != 0) && t < WAIT_LIMIT * 4) begin
         tick();
         t++;
      end
      if (t >= WAIT_LIMIT * 4) check_eq("drain_timeout", busy_a, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic               w;
      logic [ADDR_W-1:0]  a;
      logic [WDATA_W-1:0] d;
      int                 t;

      bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0;
      bus_a.req_addr  = '0;   bus_a.req_wdata = '0;  bus_a.rsp_ready = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0;
      bus_b.req_addr  = '0;   bus_b.req_wdata = '0;  bus_b.rsp_ready = 1'b0;

      // Reset state.
      repeat (3) tick();
      check_eq("rst_busy",      busy_a,             1'b0);
      check_eq("rst_req_ready", bus_a.req_ready,    1'b0);
      check_eq("rst_address",   bus_a.address,      '0);
      check_eq("rst_we",        bus_a.write_enable, 1'b0);
      check_eq("rst_re",        bus_a.read_enable,  1'b0);
      check_eq("rst_rsp_valid", bus_a.rsp_valid,    1'b0);
      check_eq("rst_wr_count",  wr_count_a,         '0);
      reset = 1'b1;
      tick();
      check_eq("idle_req_ready", bus_a.req_ready, 1'b1);

      // Single write, rsp_ready held high.
      bus_a.rsp_ready = 1'b1;
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
      bus_a.req_addr  = 33'hAA; bus_a.req_wdata = 33'h1234;
      tick();
      bus_a.req_valid = 1'b0;
      check_eq("wr_we",         bus_a.write_enable, 1'b1);
      check_eq("wr_address",    bus_a.address,      33'hAA);
      check_eq("wr_data",       bus_a.write_data,   33'h1234);
      check_eq("wr_req_ready",  bus_a.req_ready,    1'b0);
      check_eq("wr_busy",       busy_a,             1'b1);
      check_eq("wr_no_rsp",     bus_a.rsp_valid,    1'b0);
      tick();
      check_eq("wr_we_off",     bus_a.write_enable, 1'b0);
      check_eq("wr_rsp_valid",  bus_a.rsp_valid,    1'b1);
      check_eq("wr_rsp_write",  bus_a.rsp_write,    1'b1);
      check_eq("wr_rsp_rdata",  bus_a.rsp_rdata,    '0);
      tick();
      check_eq("wr_rsp_done",   bus_a.rsp_valid,    1'b0);
      check_eq("wr_count_1",    wr_count_a,         16'd1);
      check_eq("wr_idle_busy",  busy_a,             1'b0);
      check_eq("wr_idle_ready", bus_a.req_ready,    1'b1);
      check_eq("idle_addr_hold", bus_a.address,     33'hAA);

      // Single read, latency 3.
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0;
      bus_a.req_addr  = 33'hAA; bus_a.req_wdata = 33'h5A5A;
      tick();
      bus_a.req_valid = 1'b0;
      for (int i = 0; i < RL_A; i++) begin
         check_eq("rd_re_on",   bus_a.read_enable,  1'b1);
         check_eq("rd_we_off",  bus_a.write_enable, 1'b0);
         check_eq("rd_address", bus_a.address,      33'hAA);
         check_eq("rd_no_rsp",  bus_a.rsp_valid,    1'b0);
         tick();
      end
      check_eq("rd_re_off",     bus_a.read_enable, 1'b0);
      check_eq("rd_rsp_valid",  bus_a.rsp_valid,   1'b1);
      check_eq("rd_rsp_write",  bus_a.rsp_write,   1'b0);
      check_eq("rd_rsp_rdata",  bus_a.rsp_rdata,   21'h01234);
      tick();
      check_eq("rd_count_1",    rd_count_a,        16'd1);

      // Response stall with a pending request held on the input.
      bus_a.rsp_ready = 1'b0;
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0;
      bus_a.req_addr  = 33'hAA; bus_a.req_wdata = '0;
      tick();
      bus_a.req_write = 1'b1; bus_a.req_addr = 33'h1_0000_0055; bus_a.req_wdata = 33'h777;
      repeat (RL_A) tick();
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_rsp_valid", bus_a.rsp_valid,    1'b1);
         check_eq("stall_rsp_rdata", bus_a.rsp_rdata,    21'h01234);
         check_eq("stall_rsp_write", bus_a.rsp_write,    1'b0);
         check_eq("stall_req_ready", bus_a.req_ready,    1'b0);
         check_eq("stall_we",        bus_a.write_enable, 1'b0);
         check_eq("stall_re",        bus_a.read_enable,  1'b0);
         check_eq("stall_address",   bus_a.address,      33'hAA);
         tick();
      end
      bus_a.rsp_ready = 1'b1;
      tick();
      // Handshake edge: request still valid but must not have been taken.
      check_eq("hs_rsp_valid", bus_a.rsp_valid,    1'b0);
      check_eq("hs_busy",      busy_a,             1'b0);
      check_eq("hs_we",        bus_a.write_enable, 1'b0);
      check_eq("hs_req_ready", bus_a.req_ready,    1'b1);
      check_eq("hs_rd_count",  rd_count_a,         16'd2);
      bus_a.req_valid = 1'b0;
      tick();

      // Reset during the second READ cycle.
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0;
      bus_a.req_addr  = 33'h0_0000_0ABC; bus_a.req_wdata = 33'h3;
      tick();
      bus_a.req_valid = 1'b0;
      tick();
      check_eq("abort_re_before", bus_a.read_enable, 1'b1);
      reset = 1'b0;
      tick();
      check_eq("abort_req_ready", bus_a.req_ready,    1'b0);
      check_eq("abort_address",   bus_a.address,      '0);
      check_eq("abort_wdata",     bus_a.write_data,   '0);
      check_eq("abort_we",        bus_a.write_enable, 1'b0);
      check_eq("abort_re",        bus_a.read_enable,  1'b0);
      check_eq("abort_rsp_valid", bus_a.rsp_valid,    1'b0);
      check_eq("abort_rsp_write", bus_a.rsp_write,    1'b0);
      check_eq("abort_rsp_rdata", bus_a.rsp_rdata,    '0);
      check_eq("abort_busy",      busy_a,             1'b0);
      check_eq("abort_wr_count",  wr_count_a,         '0);
      check_eq("abort_rd_count",  rd_count_a,         '0);
      reset = 1'b1;
      for (int i = 0; i < 2 * RL_A + 4; i++) begin
         tick();
         check_eq("post_abort_rsp", bus_a.rsp_valid,   1'b0);
         check_eq("post_abort_re",  bus_a.read_enable, 1'b0);
      end

      // Random back-to-back mix with random backpressure.
      rsp_mode = 1;
      for (int i = 0; i < N_RANDOM; i++) begin
         w       = 1'($urandom_range(0, 1));
         a[31:0] = $urandom();
         a[32]   = 1'($urandom_range(0, 1));
         d[31:0] = $urandom();
         d[32]   = 1'($urandom_range(0, 1));
         if (w) n_wr_issued++;
         else n_rd_issued++;
         issue(w, a, d);
      end
      drain();
      rsp_mode = 0;
      bus_a.rsp_ready = 1'b1;
      check_eq("rand_queue_empty", exp_q.size(), 0);
      check_eq("rand_wr_total",    wr_count_a,   sat_a(n_wr_issued));
      check_eq("rand_rd_total",    rd_count_a,   sat_a(n_rd_issued));

      // dut_b: 17 writes saturate a 4-bit counter.
      bus_b.rsp_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         t = 0;
         while (!bus_b.req_ready && t < WAIT_LIMIT) begin
            tick();
            t++;
         end
         if (t >= WAIT_LIMIT) check_eq("b_ready_timeout", bus_b.req_ready, 1'b1);
         bus_b.req_valid = 1'b1; bus_b.req_write = 1'b1;
         bus_b.req_addr  = ADDR_W'(i); bus_b.req_wdata = WDATA_W'(i);
         tick();
         bus_b.req_valid = 1'b0;
         t = 0;
         while (busy_b && t < WAIT_LIMIT) begin
            tick();
            t++;
         end
         if (t >= WAIT_LIMIT) check_eq("b_busy_timeout", busy_b, 1'b0);
         check_eq("b_wr_count", wr_count_b, (i + 1 > 15) ? 15 : i + 1);
      end

      // dut_b: single-cycle read.
      bus_b.req_valid = 1'b1; bus_b.req_write = 1'b0; bus_b.req_addr = 33'h77;
      tick();
      bus_b.req_valid = 1'b0;
      check_eq("b_re_on",     bus_b.read_enable, 1'b1);
      tick();
      check_eq("b_re_off",    bus_b.read_enable, 1'b0);
      check_eq("b_rsp_valid", bus_b.rsp_valid,   1'b1);
      check_eq("b_rsp_rdata", bus_b.rsp_rdata,   slave_fn(33'h77));
      tick();
      check_eq("b_rd_count",  rd_count_b,        4'd1);
      check_eq("b_wr_sat",    wr_count_b,        4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_bus_master_bridge.md
REG_BUS_MASTER_BRIDGE -- requirements
Module: reg_bus_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 33, width of the register-bus address and of req_addr.
REQ-002 SHALL have parameter WDATA_W, default 33, width of write data.
REQ-003 SHALL have parameter RDATA_W, default 21, width of read data.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal range 1..15: the number of cycles read_enable is held.
REQ-005 SHALL have parameter CNT_W, default 16, width of the transaction counters.
REQ-006 clock  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  bridge accepts request.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  target register address.
REQ-012 req_wdata  input  WDATA_W  write payload.
REQ-013 address  output  ADDR_W  register-bus address.
REQ-014 write_enable  output  1  register-bus write strobe.
REQ-015 write_data  output  WDATA_W  register-bus write data.
REQ-016 read_enable  output  1  register-bus read strobe.
REQ-017 read_data  input  RDATA_W  register-bus read return, combinational from the slave.
REQ-018 rsp_valid  output  1  response present.
REQ-019 rsp_ready  input  1  consumer accepts response.
REQ-020 rsp_write  output  1  response belongs to a write.
REQ-021 rsp_rdata  output  RDATA_W  read result; 0 for writes.
REQ-022 busy  output  1  state is not IDLE.
REQ-023 wr_count, rd_count  output  CNT_W each  completed writes/reads.

Function
REQ-024 SHALL implement FSM states IDLE, WRITE, READ, RESP; all outputs SHALL be registered or decoded from the state register only.
REQ-025 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-026 On req_valid&&req_ready, the bridge SHALL capture req_write, req_addr and req_wdata, and go to WRITE if req_write=1, else to READ.
REQ-027 WRITE SHALL last exactly 1 cycle with write_enable=1, address=captured addr, write_data=captured wdata; the next state SHALL be RESP.
REQ-028 READ SHALL last READ_LATENCY cycles with read_enable=1 and address=captured addr, tracked by a down-counter.
REQ-029 rsp_rdata SHALL sample read_data at the end of the last READ cycle; the next state SHALL be RESP.
REQ-030 write_enable and read_enable SHALL never be 1 simultaneously, and SHALL be 0 outside WRITE/READ respectively.
REQ-031 address and write_data SHALL hold their last value while idle.
REQ-032 RESP SHALL assert rsp_valid, with rsp_write and rsp_rdata held stable until rsp_ready.
REQ-033 On rsp_valid&&rsp_ready, the FSM SHALL go to IDLE and the matching counter SHALL increment.
REQ-034 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-035 Counters SHALL saturate at all-ones and never wrap.
REQ-036 A write response SHALL carry rsp_rdata=0.
REQ-037 Minimum turnaround SHALL be: write 3 cycles, read 2+READ_LATENCY cycles (accept to response handshake, rsp_ready held 1).

Reset
REQ-038 Asserting reset at any time, including mid-transaction, SHALL force state IDLE and zero every output and counter; an aborted transaction SHALL produce no response.
REQ-039 After deassertion, the first accepted request SHALL behave as from power-up.

Structure
REQ-040 The FSM state enum and the READ_LATENCY legal-range constants SHALL live in the shared package reg_bus_pkg.
REQ-041 The two saturating counters SHALL be instances of one sub-module, sat_counter.
REQ-042 An elaboration-time check SHALL reject READ_LATENCY outside 1..15.

Verification
REQ-043 Write addr=33'hAA, wdata=16'h1234, rsp_ready=1 -> write_enable high for 1 cycle with address 33'hAA; rsp_valid 1 cycle later with rsp_write=1, rsp_rdata=0; wr_count=1.
REQ-044 Read addr=33'hAA, READ_LATENCY=3, slave returns 21'h01234 -> read_enable high exactly 3 cycles; rsp_rdata=21'h01234; rd_count=1.
REQ-045 rsp_ready held 0 for 5 cycles with req_valid held 1 -> rsp_valid and rsp_rdata stable, req_ready=0, no bus strobe.
REQ-046 reset asserted during the 2nd READ cycle (READ_LATENCY=3) -> next cycle all outputs 0 and busy=0; no rsp_valid after release.
REQ-047 CNT_W=4 with 17 writes -> wr_count stays 4'hF.
REQ-048 Random back-to-back mix of 1000 reads and writes -> strobes never overlap and responses come in order; counters equal the scoreboard totals.
